// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
//
// Contents:
//   branch_kind_t : encoding of the branch descriptor kind field
//   pc_state_t    : program-counter FSM states (BOOT, RUN, FLUSH)
//   INSTR_BYTES   : fetch stride, one Thumb halfword
//   PIPE_OFFSET   : the PC reads as the branch address plus 4
//   FLUSH_CNT_W   : width of the flush counter (FLUSH_CYCLES is 1..7)
package pc_pkg;

  typedef enum logic [1:0] {
    BK_COND   = 2'd0,  // conditional branch, imm8
    BK_UNCOND = 2'd1,  // unconditional branch, imm11
    BK_BL     = 2'd2,  // branch with link, imm11 (only with BRANCH_LINK_EN)
    BK_RSVD   = 2'd3   // reserved, never taken
  } branch_kind_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_t;

  localparam int INSTR_BYTES = 2;
  localparam int PIPE_OFFSET = 4;
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pc_unit_branch_target_adder.sv
// Combinational branch target computation.
//
// target = branch_pc + PIPE_OFFSET + sext(imm << 1), modulo 2^ADDR_W,
// with bit 0 forced to 0.
//
// Ports:
//   branch_pc  : address of the branch instruction
//   branch_imm : raw 11-bit immediate
//   use_imm8   : 1 = conditional form (imm8 in bits [7:0]), 0 = imm11 form
//   target     : halfword-aligned redirect address
//
// ADDR_W must be at least 12 so the imm11 offset fits before extension.
module branch_target_adder
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [10:0]       branch_imm,
  input  logic              use_imm8,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] sum;

  always_comb begin
    // After the shift the imm8 form has its sign at bit 8 and the imm11
    // form at bit 11; replicate that bit up to the full address width.
    if (use_imm8) begin
      offset = {{(ADDR_W-9){branch_imm[7]}}, branch_imm[7:0], 1'b0};
    end else begin
      offset = {{(ADDR_W-12){branch_imm[10]}}, branch_imm, 1'b0};
    end
    sum    = branch_pc + ADDR_W'(PIPE_OFFSET) + offset;
    target = {sum[ADDR_W-1:1], 1'b0};
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage of the Thumb-subset core.
//
// Holds the fetch address, advances it by one halfword per cycle, redirects
// on taken branches from the condition checker and raises flush for
// FLUSH_CYCLES cycles afterwards so wrong-path instructions are squashed.
//
// Optional feature macro: BRANCH_LINK_EN
//   defined   : branch_kind 2 is BL; lr captures (branch_pc + 4) | 1
//   undefined : no lr port; branch_kind 2 is reserved (never taken)
//
// Ports:
//   clk, not_reset  : clock, asynchronous active-low reset
//   stall           : hold the PC this cycle (overridden by a taken branch)
//   branch_valid    : branch descriptor present, aligned with branch_ok
//   branch_ok       : condition verdict
//   branch_kind     : see branch_kind_t
//   branch_pc       : address of the branch instruction
//   branch_imm      : raw immediate (imm8 uses bits [7:0])
//   pc              : current fetch address
//   pc_valid        : pc is a real fetch request
//   flush           : squash instructions in flight
//   lr              : link register (BRANCH_LINK_EN only)
//   dbg_state       : current FSM state
//
// Handshake: there is no backpressure on the outputs. pc_valid qualifies pc
// every cycle; a branch descriptor is consumed on any edge where
// branch_valid is high and the FSM is in RUN, otherwise it is dropped.
// All outputs are driven straight from flops.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              not_reset,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic              branch_ok,
  input  logic [1:0]        branch_kind,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [10:0]       branch_imm,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
`ifdef BRANCH_LINK_EN
  output logic [ADDR_W-1:0] lr,
`endif
  output pc_state_t         dbg_state
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  pc_state_t               state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic                    flush_q;
  logic                    valid_q;
  logic [ADDR_W-1:0]       target;
  logic                    kind_takeable;
  logic                    taken;
  branch_kind_t            kind;

  assign kind = branch_kind_t'(branch_kind);

  always_comb begin
    kind_takeable = 1'b0;
    case (kind)
      BK_COND:   kind_takeable = 1'b1;
      BK_UNCOND: kind_takeable = 1'b1;
`ifdef BRANCH_LINK_EN
      BK_BL:     kind_takeable = 1'b1;
`endif
      default:   kind_takeable = 1'b0;
    endcase
  end

  // Descriptors seen outside RUN are wrong-path (FLUSH) or pre-fetch (BOOT).
  assign taken = (state_q == ST_RUN) & branch_valid & branch_ok & kind_takeable;

  branch_target_adder #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .branch_pc  (branch_pc),
    .branch_imm (branch_imm),
    .use_imm8   (kind == BK_COND),
    .target     (target)
  );

  // Next-state and next-PC logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: begin
        // First edge after reset release only arms fetch; pc stays RESET_PC.
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (taken) begin
          pc_d    = target;
          cnt_d   = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end else if (!stall) begin
          pc_d = pc_q + ADDR_W'(INSTR_BYTES);
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          pc_d = pc_q + ADDR_W'(INSTR_BYTES);
        end
        // Counter runs regardless of stall so the flush window is fixed length.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == FLUSH_CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      // Registered decodes of the next state keep flush/pc_valid flop-driven.
      flush_q <= (state_d == ST_FLUSH);
      valid_q <= (state_d != ST_BOOT);
    end
  end

`ifdef BRANCH_LINK_EN
  logic [ADDR_W-1:0] lr_q;
  logic [ADDR_W-1:0] link_addr;

  // Return address with the Thumb bit set.
  assign link_addr = (branch_pc + ADDR_W'(PIPE_OFFSET)) | ADDR_W'(1);

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      lr_q <= '0;
    end else if (taken && (kind == BK_BL)) begin
      lr_q <= link_addr;
    end
  end

  assign lr = lr_q;
`endif

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign flush     = flush_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (default parameters, with or without
// BRANCH_LINK_EN). The driver applies one cycle of stimulus per call,
// advances a reference model and queues the expected outputs; a monitor
// compares the DUT against the queue after every rising edge.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int          ADDR_W       = 32;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;
`ifdef BRANCH_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        not_reset    = 1'b0;
  logic        stall        = 1'b0;
  logic        branch_valid = 1'b0;
  logic        branch_ok    = 1'b0;
  logic [1:0]  branch_kind  = 2'd0;
  logic [31:0] branch_pc    = '0;
  logic [10:0] branch_imm   = '0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] lr;
  pc_state_t   dbg_state;

`ifndef BRANCH_LINK_EN
  assign lr = '0;
`endif

  pc_unit #(
    .ADDR_W       (ADDR_W),
    .RESET_PC     (RESET_PC),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .not_reset    (not_reset),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_ok    (branch_ok),
    .branch_kind  (branch_kind),
    .branch_pc    (branch_pc),
    .branch_imm   (branch_imm),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .flush        (flush),
`ifdef BRANCH_LINK_EN
    .lr           (lr),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] lr;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_flush_left: flush cycles still to be shown after the coming edge.
  bit          m_boot;
  int          m_flush_left;
  logic [31:0] m_pc;
  logic [31:0] m_lr;

  function automatic logic [31:0] ref_target(input logic [31:0] bpc, input logic [10:0] imm,
                                              input logic [1:0] kind);
    logic [7:0] i8;
    int         off;
    i8 = imm[7:0];
    if (kind == 2'd0) off = 2 * int'($signed(i8));
    else              off = 2 * int'($signed(imm));
    return (bpc + 32'd4 + 32'(off)) & 32'hFFFF_FFFE;
  endfunction

  function automatic bit ref_taken(input logic bv, input logic ok, input logic [1:0] kind);
    bit kind_ok;
    kind_ok = (kind == 2'd0) || (kind == 2'd1) || (LINK_EN && kind == 2'd2);
    return bv && ok && kind_ok;
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.pc       = m_pc;
    e.pc_valid = 1'b1;
    e.flush    = (m_flush_left > 0);
    e.lr       = m_lr;
    exp_q.push_back(EXP_W'(e));
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic bv, input logic ok, input logic [1:0] k,
                      input logic [31:0] bpc, input logic [10:0] imm);
    @(negedge clk);
    stall        = s;
    branch_valid = bv;
    branch_ok    = ok;
    branch_kind  = k;
    branch_pc    = bpc;
    branch_imm   = imm;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_flush_left > 0) begin
      if (!s) m_pc = m_pc + 32'd2;
      m_flush_left--;
    end else if (ref_taken(bv, ok, k)) begin
      m_pc         = ref_target(bpc, imm, k);
      m_flush_left = FLUSH_CYCLES;
      if (LINK_EN && k == 2'd2) m_lr = (bpc + 32'd4) | 32'd1;
    end else if (!s) begin
      m_pc = m_pc + 32'd2;
    end
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 11'd0);
  endtask

  // Asserts reset between edges and checks the outputs react without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    not_reset    = 1'b0;
    stall        = 1'b0;
    branch_valid = 1'b0;
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pc_valid", 32'(pc_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_BOOT));
    if (LINK_EN) check("rst_lr", lr, 32'd0);
    m_boot       = 1'b1;
    m_flush_left = 0;
    m_pc         = RESET_PC;
    m_lr         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("boot_pc_valid", 32'(pc_valid), 32'd0);
    @(negedge clk);
    not_reset = 1'b1;
    // The edge after release is the BOOT->RUN edge; model it here.
    m_boot = 1'b0;
    push_expect();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        check("pc", pc, e.pc);
        check("pc_valid", 32'(pc_valid), 32'(e.pc_valid));
        check("flush", 32'(flush), 32'(e.flush));
        if (LINK_EN) check("lr", lr, e.lr);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    idle(3);
    // conditional taken, imm8 = -2 -> target 0x100
    step(1'b0, 1'b1, 1'b1, 2'd0, 32'h100, 11'h0FE);
    idle(2);
    // same descriptor, not taken
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'h100, 11'h0FE);
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'h100, 11'h0FE);
    // stall overridden by unconditional branch -> 0x224, then held
    step(1'b1, 1'b1, 1'b1, 2'd1, 32'h200, 11'h010);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 11'd0);
    idle(2);
    // wrap to zero, then a wrong-path branch during FLUSH
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFC, 11'h000);
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'h300, 11'h010);
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'h400, 11'h010);
    idle(1);
    // reserved kind, and BL (taken only with link support)
    step(1'b0, 1'b1, 1'b1, 2'd3, 32'h500, 11'h020);
    step(1'b0, 1'b1, 1'b1, 2'd2, 32'h40, 11'h000);
    idle(3);
    // negative imm11
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'h1000, 11'h7F0);
    idle(3);
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), $urandom, 11'($urandom_range(0, 2047)));
    end
    // reset in the middle of a flush window
    idle(2);
    step(1'b0, 1'b1, 1'b1, 2'd2, 32'h40, 11'h000);
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'h80, 11'h004);
    do_reset();
    idle(3);
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), $urandom, 11'($urandom_range(0, 2047)));
    end
    idle(1);
    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the Thumb-subset core, directly downstream of the branch condition checker. It holds the fetch address and advances it by one halfword per cycle. It consumes the checker's registered `Ok` verdict together with the branch descriptor and redirects fetch to the computed target. After every taken branch it flags the wrong-path instructions already in flight so downstream stages squash them.

## Interface
Parameters:
- `ADDR_W`, default 32: PC width.
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; must be halfword aligned.
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high after a taken branch; legal range 1–7.

Ports:
- `clk` input, 1: single clock; all state changes on the rising edge.
- `not_reset` input, 1: asynchronous, active-low reset.
- `stall` input, 1: hold the PC this cycle.
- `branch_valid` input, 1: a branch descriptor is present; aligned with `branch_ok`.
- `branch_ok` input, 1: condition verdict from the branch condition checker.
- `branch_kind` input, 2: 0 = conditional (imm8), 1 = unconditional (imm11), 2 = BL (macro only), 3 = reserved and treated as not taken.
- `branch_pc` input, `ADDR_W`: address of the branch instruction.
- `branch_imm` input, 11: raw immediate; for conditional branches only bits [7:0] are used.
- `pc` output, `ADDR_W`: current fetch address.
- `pc_valid` output, 1: `pc` is a real fetch request.
- `flush` output, 1: squash the instructions currently in flight.
- `lr` output, `ADDR_W`: link register value; present only with `BRANCH_LINK_EN`.

## Operation
- States: BOOT, RUN, FLUSH.
- **Taken branch:** `branch_valid & branch_ok & (branch_kind != 3)`, sampled in RUN only.
- **Target:** `branch_pc + 4 + sext(imm << 1)`.
  - imm8 is sign-extended from bit 8 after the shift; imm11 is sign-extended from bit 11.
  - Arithmetic is modulo 2^`ADDR_W`; the target wraps silently and bit 0 is forced to 0.
- **BOOT:** entered on reset. `pc_valid` = 0. Moves to RUN on the first edge after reset release.
- **RUN:**
  - Taken branch: load `pc` with the target, load the flush counter with `FLUSH_CYCLES`, go to FLUSH.
  - Else if `stall`: hold `pc`.
  - Else: `pc <= pc + 2`, wrapping modulo 2^`ADDR_W`.
  - A taken branch overrides `stall`.
- **FLUSH:**
  - `flush` = 1 and the counter decrements every cycle, including stalled cycles.
  - `pc` increments by 2 unless `stall` is high.
  - `branch_valid` is ignored, because those are wrong-path branches.
  - When the counter reaches 1, return to RUN on that edge.
- `pc_valid` = 1 in both RUN and FLUSH.
- **Reset mid-operation:** any state returns immediately (asynchronously) to BOOT. The flush counter clears.
- **Reset values:** `pc` = `RESET_PC`, `pc_valid` = 0, `flush` = 0, `lr` = 0.

## Timing
- A taken branch sampled at edge k puts the target on `pc` from edge k.
- `flush` is high for exactly `FLUSH_CYCLES` cycles, starting at edge k.
- Branch-to-redirect latency is therefore 1 cycle from `branch_valid` sampled high.
- All outputs come directly from flops; there are no combinational paths from input to output.
- Back-to-back taken branches:
  - The first is accepted.
  - Any arriving within the following `FLUSH_CYCLES` cycles are dropped.

## Configuration
- Macro: `BRANCH_LINK_EN`.
- **Defined:**
  - `branch_kind` = 2 is decoded as BL. Target uses the imm11 rule.
  - On a taken BL, `lr <= branch_pc + 4` with bit 0 set to 1 (Thumb bit).
  - `lr` holds its value otherwise.
- **Undefined:**
  - The `lr` port and register do not exist.
  - `branch_kind` = 2 is treated as reserved and is never taken.

## Structure
- Package `pc_pkg`:
  - `branch_kind_t` enum.
  - State enum `pc_state_t`.
  - Constants `INSTR_BYTES` = 2 and `PIPE_OFFSET` = 4.
- Sub-module `branch_target_adder` (combinational): sign-extension, shift and add, parameterised on `ADDR_W`.

## Test plan
- **Reset and increment:** release `not_reset`, no stall.
  - Expect `pc_valid` 0 in the first cycle.
  - Then `pc` = 0x0, 0x2, 0x4, and so on.
- **Conditional branch taken:** `branch_pc` = 0x100, `branch_imm` = 0x0FE (imm8 = -2), kind 0, ok = 1.
  - Expect `pc` = 0x100 next.
  - Expect `flush` high for exactly 2 cycles.
- **Not taken:** same descriptor with ok = 0.
  - Expect `pc` to keep incrementing by 2 and `flush` to stay 0.
- **Stall vs branch:** `stall` = 1 with a taken unconditional branch, `branch_pc` = 0x200, imm11 = 0x010.
  - Expect `pc` = 0x224; the stall is overridden.
  - In the next cycle, with `stall` still 1, expect `pc` held at 0x224.
- **Branch during FLUSH and wrap:**
  - A second taken branch one cycle after the first is ignored.
  - `branch_pc` = 0xFFFF_FFFC with imm11 = 0 gives `pc` = 0x0000_0000.
- **Link (`BRANCH_LINK_EN`) and reset mid-FLUSH:**
  - Taken BL at `branch_pc` = 0x40 gives `lr` = 0x45.
  - Asserting `not_reset` low during FLUSH gives `pc` = `RESET_PC` and `flush` = 0 immediately.
